// File: rtl/uart_tx_framer_if.sv
// Handshake and line bundle for the UART transmit framer.
// The cts_n flow-control input exists only when UART_TX_CTS_EN is defined.
interface uart_tx_framer_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic [1:0]           parity_type;
    logic                 stop2;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_out;
`ifdef UART_TX_CTS_EN
    logic                 cts_n;

    modport master (
        output baud_tick, tx_valid, tx_data, parity_type, stop2, cts_n,
        input  tx_ready, tx_busy, tx_done, tx_out
    );

    modport slave (
        input  baud_tick, tx_valid, tx_data, parity_type, stop2, cts_n,
        output tx_ready, tx_busy, tx_done, tx_out
    );
`else
    modport master (
        output baud_tick, tx_valid, tx_data, parity_type, stop2,
        input  tx_ready, tx_busy, tx_done, tx_out
    );

    modport slave (
        input  baud_tick, tx_valid, tx_data, parity_type, stop2,
        output tx_ready, tx_busy, tx_done, tx_out
    );
`endif
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, 1 or 2 stops.
// Optional macro UART_TX_CTS_EN gates the frame start on an active-low cts_n.
module uart_tx_framer #(
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_framer_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

    // 2'b01 selects odd parity; the caller has already decided parity is on.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic [1:0]           ptype);
        logic p;
        p = ^data;
        parity_bit = (ptype == 2'b01) ? ~p : p;
    endfunction

    function automatic logic parity_on(input logic [1:0] ptype);
        parity_on = ptype[1] ^ ptype[0];
    endfunction

    logic [2:0]           state_r, state_s;
    logic [2:0]           idx_r, idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_bit_r, par_bit_s;
    logic                 par_en_r, par_en_s;
    logic                 stop2_r, stop2_s;
    logic                 stop_second_r, stop_second_s;
    logic                 done_s;
    logic                 out_s;
    logic                 out_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 cts_ok_s;
    logic                 accept_s;

`ifdef UART_TX_CTS_EN
    assign cts_ok_s = ~bus.cts_n;
`else
    assign cts_ok_s = 1'b1;
`endif

    assign accept_s = bus.tx_valid & ready_r;

    // Next-state, bit index, latched frame fields and done strobe.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        shift_s       = shift_r;
        par_bit_s     = par_bit_r;
        par_en_s      = par_en_r;
        stop2_s       = stop2_r;
        stop_second_s = stop_second_r;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s       = ST_ARM;
                    shift_s       = bus.tx_data;
                    par_bit_s     = parity_bit(bus.tx_data, bus.parity_type);
                    par_en_s      = parity_on(bus.parity_type);
                    stop2_s       = bus.stop2;
                    stop_second_s = 1'b0;
                    idx_s         = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (bus.baud_tick && cts_ok_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_ARM;
                end
            end
            ST_START: begin
                if (bus.baud_tick) begin
                    state_s = ST_DATA;
                    idx_s   = 3'd0;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bus.baud_tick) begin
                    if (idx_r < LAST_IDX) begin
                        idx_s   = idx_r + 3'd1;
                        shift_s = shift_r >> 1;
                    end else if (par_en_r) begin
                        state_s = ST_PARITY;
                    end else begin
                        state_s = ST_STOP;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bus.baud_tick) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bus.baud_tick) begin
                    if (stop2_r && !stop_second_r) begin
                        stop_second_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx_out can be registered.
    always_comb begin
        out_s = 1'b1;
        case (state_s)
            ST_START:  out_s = 1'b0;
            ST_DATA:   out_s = shift_s[0];
            ST_PARITY: out_s = par_bit_r;
            default:   out_s = 1'b1;
        endcase
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= 3'd0;
            shift_r       <= '0;
            par_bit_r     <= 1'b0;
            par_en_r      <= 1'b0;
            stop2_r       <= 1'b0;
            stop_second_r <= 1'b0;
            out_r         <= 1'b1;
            ready_r       <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            shift_r       <= shift_s;
            par_bit_r     <= par_bit_s;
            par_en_r      <= par_en_s;
            stop2_r       <= stop2_s;
            stop_second_r <= stop_second_s;
            out_r         <= out_s;
            ready_r       <= (state_s == ST_IDLE);
            busy_r        <= (state_s != ST_IDLE);
            done_r        <= done_s;
        end
    end

    assign bus.tx_out   = out_r;
    assign bus.tx_ready = ready_r;
    assign bus.tx_busy  = busy_r;
    assign bus.tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: frames queued at send time, checked by a line monitor.
module tb_uart_tx_framer;

    typedef struct {
        logic [11:0] seq;   // slot 0 (start bit) is seq[len-1]
        int          len;
    } frame_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   frames_pushed;
    int   frames_done;
    int   tick_cnt;
    frame_t exp_q[$];

    uart_tx_framer_if #(.DATA_BITS(8)) tif ();

    uart_tx_framer #(.DATA_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One baud_tick every 16 clocks, driven away from the active edge.
    initial begin
        tif.baud_tick = 1'b0;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tif.baud_tick = (tick_cnt == 15);
            tick_cnt = (tick_cnt + 1) % 16;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [11:0] seq, input int len);
        frame_t f;
        f.seq = seq;
        f.len = len;
        exp_q.push_back(f);
        frames_pushed++;
    endtask

    task automatic wait_accept(output bit done_at_accept);
        bit ok;
        ok = 1'b0;
        done_at_accept = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (tif.tx_valid && tif.tx_ready) begin
                ok = 1'b1;
                done_at_accept = tif.tx_done;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        #1;
    endtask

    // Drive one word, then scramble the inputs to show they are latched.
    task automatic send(input logic [7:0] data, input logic [1:0] pt, input logic s2,
                        input logic [11:0] seq, input int len);
        bit d;
        push_frame(seq, len);
        tif.tx_data     = data;
        tif.parity_type = pt;
        tif.stop2       = s2;
        tif.tx_valid    = 1'b1;
        wait_accept(d);
        tif.tx_valid    = 1'b0;
        tif.tx_data     = ~data;
        tif.parity_type = ~pt;
        tif.stop2       = ~s2;
    endtask

    task automatic wait_frames();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (frames_done == frames_pushed) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("frame_timeout", 32'(frames_done), 32'(frames_pushed));
    endtask

    // Monitor: on each falling start edge pop a frame and check every slot mid-bit.
    initial begin : monitor
        frame_t f;
        logic   prev;
        bit     early;
        bit     aborted;
        int     slot;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tif.tx_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 32'(tif.tx_out), 32'd1);
                end else begin
                    f = exp_q.pop_front();
                    early = 1'b0;
                    aborted = 1'b0;
                    for (int k = 1; k <= f.len * 16; k++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k % 16 == 8) begin
                            slot = k / 16;
                            check($sformatf("frame_bit slot%0d", slot),
                                  32'(tif.tx_out), 32'(f.seq[f.len - 1 - slot]));
                        end
                        if (k == 8) begin
                            check("busy_in_frame", 32'(tif.tx_busy), 32'd1);
                            check("ready_in_frame", 32'(tif.tx_ready), 32'd0);
                        end
                        if (k < f.len * 16 && tif.tx_done) early = 1'b1;
                    end
                    if (!aborted) begin
                        check("done_early", 32'(early), 32'd0);
                        check("done_at_end", 32'(tif.tx_done), 32'd1);
                        check("ready_at_end", 32'(tif.tx_ready), 32'd1);
                    end
                    frames_done++;
                end
            end
            prev = tif.tx_out;
        end
    end

    initial begin : stimulus
        bit done_at;
        int cnt;
        bit fell;
        total = 0;
        bad = 0;
        frames_pushed = 0;
        frames_done = 0;
        rst_n = 1'b0;
        tif.tx_valid = 1'b0;
        tif.tx_data = 8'h00;
        tif.parity_type = 2'b00;
        tif.stop2 = 1'b0;
`ifdef UART_TX_CTS_EN
        tif.cts_n = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_out", 32'(tif.tx_out), 32'd1);
        check("reset_ready", 32'(tif.tx_ready), 32'd1);
        check("reset_busy", 32'(tif.tx_busy), 32'd0);
        check("reset_done", 32'(tif.tx_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 0x55 even, one stop; done lands 176 clks after the line falls.
        send(8'h55, 2'b10, 1'b0, 12'b0_0_10101010_0_1, 11);
        wait_frames();
        send(8'h55, 2'b01, 1'b0, 12'b0_0_10101010_1_1, 11);
        wait_frames();
        send(8'h07, 2'b01, 1'b0, 12'b0_0_11100000_0_1, 11);
        wait_frames();
        send(8'hA3, 2'b11, 1'b1, 12'b0_0_11000101_1_1, 11);
        wait_frames();
        send(8'hA3, 2'b00, 1'b1, 12'b0_0_11000101_1_1, 11);
        wait_frames();

        // Back-to-back with tx_valid held; next word is set up mid-frame.
        push_frame(12'b00_0_11110000_1, 10);
        push_frame(12'b0_00001111_1_1_1, 12);
        tif.tx_data = 8'h0F;
        tif.parity_type = 2'b00;
        tif.stop2 = 1'b0;
        tif.tx_valid = 1'b1;
        wait_accept(done_at);
        tif.tx_data = 8'hF0;
        tif.parity_type = 2'b01;
        tif.stop2 = 1'b1;
        wait_accept(done_at);
        check("b2b_accept_after_done", 32'(done_at), 32'd1);
        tif.tx_valid = 1'b0;
        tif.tx_data = 8'hFF;
        tif.parity_type = 2'b10;
        tif.stop2 = 1'b0;
        wait_frames();

        // Reset in the middle of data bit 3.
        send(8'h81, 2'b10, 1'b0, 12'b0_0_10000001_0_1, 11);
        fell = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tif.tx_out) begin
                fell = 1'b1;
                break;
            end
        end
        check("rst_test_start_seen", 32'(fell), 32'd1);
        repeat (72) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_tx_out", 32'(tif.tx_out), 32'd1);
        check("midreset_ready", 32'(tif.tx_ready), 32'd1);
        check("midreset_done", 32'(tif.tx_done), 32'd0);
        check("midreset_busy", 32'(tif.tx_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frames();
        send(8'h3C, 2'b10, 1'b0, 12'b0_0_00111100_0_1, 11);
        wait_frames();

`ifdef UART_TX_CTS_EN
        // Held off by cts_n for 5 ticks, then released; raising it mid-frame is ignored.
        tif.cts_n = 1'b1;
        send(8'h3C, 2'b10, 1'b0, 12'b0_0_00111100_0_1, 11);
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (!tif.tx_out) cnt++;
        end
        check("cts_hold_high", 32'(cnt), 32'd0);
        tif.cts_n = 1'b0;
        cnt = 0;
        fell = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (!tif.tx_out) begin
                fell = 1'b1;
                break;
            end
        end
        check("cts_start_next_tick", 32'(fell && cnt <= 17), 32'd1);
        tif.cts_n = 1'b1;
        wait_frames();
        tif.cts_n = 1'b0;
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
